// File: rtl/game_pkg.sv
// Shared game-wide constants: state codes, playfield/sprite geometry, motion FSM encoding.
package game_pkg;

  localparam logic [3:0] TITLE  = 4'd0;
  localparam logic [3:0] STAGE1 = 4'd2;
  localparam logic [3:0] STAGE2 = 4'd4;
  localparam logic [3:0] STAGE3 = 4'd6;

  localparam int SPRITE_W = 10;
  localparam int SPRITE_H = 10;
  localparam int PLAY_W   = 320;
  localparam int PLAY_H   = 240;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    FROZEN = 2'd2
  } fsm_t;

  function automatic logic is_stage(input logic [3:0] s);
    return (s == STAGE1) || (s == STAGE2) || (s == STAGE3);
  endfunction

  // Nibble slot of player_state owned by a stage code.
  function automatic logic [1:0] stage_slot(input logic [3:0] s);
    case (s)
      STAGE2:  return 2'd1;
      STAGE3:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/anim_counter.sv
// Tick divider plus modulo-FRAMES frame counter for sprite animation.
// Latency: frame_nxt is the combinational next frame, registered on the same edge.
// Backpressure: none; clr dominates en, en advances the divider by one tick.
module anim_counter #(
  parameter int ANIM_DIV  = 8,
  parameter int TITLE_DIV = 16,
  parameter int FRAMES    = 4,
  parameter int DIV_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       title,
  output logic [3:0] frame_nxt
);

  localparam logic [DIV_W-1:0] ANIM_LAST  = DIV_W'(ANIM_DIV - 1);
  localparam logic [DIV_W-1:0] TITLE_LAST = DIV_W'(TITLE_DIV - 1);
  localparam logic [3:0]       FRAME_LAST = 4'(FRAMES - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [3:0]       frame_q;
  logic             wrap;

  always_comb begin
    wrap      = en && (div_q == (title ? TITLE_LAST : ANIM_LAST));
    div_d     = div_q;
    frame_nxt = frame_q;
    if (clr) begin
      div_d     = '0;
      frame_nxt = '0;
    end else if (en) begin
      div_d = wrap ? '0 : div_q + DIV_W'(1);
      if (wrap) begin
        frame_nxt = (frame_q == FRAME_LAST) ? 4'd0 : frame_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      frame_q <= frame_nxt;
    end
  end

endmodule

// File: rtl/player_motion.sv
// Player position, clamping, spawn and walk/title animation frame indices.
// Latency: one cycle from tick (or a state change) to registered outputs.
// Backpressure: none; every tick is consumed, stage entry discards a coincident tick.
module player_motion
  import game_pkg::*;
#(
  parameter int STEP      = 1,
  parameter int X_MAX     = PLAY_W - SPRITE_W,
  parameter int Y_MAX     = PLAY_H - SPRITE_H,
  parameter int START_X   = 10,
  parameter int START_Y   = 110,
  parameter int ANIM_DIV  = 8,
  parameter int TITLE_DIV = 16,
  parameter int FRAMES    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  state,
  input  logic        tick,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  output logic [26:0] player_x,
  output logic [26:0] player_y,
  output logic [11:0] player_state,
  output logic        moving
);

  localparam logic signed [9:0] STEP_S  = 10'(STEP);
  localparam logic signed [9:0] XMAX_S  = 10'(X_MAX);
  localparam logic signed [9:0] YMAX_S  = 10'(Y_MAX);
  localparam logic [8:0]        START_XV = 9'(START_X);
  localparam logic [8:0]        START_YV = 9'(START_Y);

  logic [3:0]  prev_q;
  fsm_t        fsm_q, fsm_d;
  logic [8:0]  x_q, y_q;
  logic [11:0] nib_q, nib_d;

  logic        in_stage, in_title, entry, title_entry, stage_tick, title_tick;
  logic [1:0]  slot;
  logic signed [9:0] dx, dy, nx_s, ny_s;
  logic [8:0]  nx, ny;
  logic        move;
  logic        cnt_clr, cnt_en;
  logic [3:0]  frame_nxt;

  assign in_stage    = is_stage(state);
  assign in_title    = (state == TITLE);
  assign entry       = in_stage && (state != prev_q);
  assign title_entry = in_title && (prev_q != TITLE);
  assign stage_tick  = in_stage && !entry && tick;
  assign title_tick  = in_title && !title_entry && tick;
  assign slot        = stage_slot(state);

  // Opposing keys cancel; 10-bit signed sums keep x-1 at 0 from wrapping.
  always_comb begin
    dx = 10'sd0;
    dy = 10'sd0;
    if (key_right && !key_left) dx = STEP_S;
    else if (key_left && !key_right) dx = -STEP_S;
    if (key_down && !key_up) dy = STEP_S;
    else if (key_up && !key_down) dy = -STEP_S;
    nx_s = $signed({1'b0, x_q}) + dx;
    ny_s = $signed({1'b0, y_q}) + dy;
    if (nx_s < 10'sd0)       nx = 9'd0;
    else if (nx_s > XMAX_S)  nx = XMAX_S[8:0];
    else                     nx = nx_s[8:0];
    if (ny_s < 10'sd0)       ny = 9'd0;
    else if (ny_s > YMAX_S)  ny = YMAX_S[8:0];
    else                     ny = ny_s[8:0];
  end

  assign move    = (dx != 10'sd0) || (dy != 10'sd0);
  assign cnt_clr = entry || title_entry || (stage_tick && !move);
  assign cnt_en  = (stage_tick && move) || title_tick;

  anim_counter #(
    .ANIM_DIV  (ANIM_DIV),
    .TITLE_DIV (TITLE_DIV),
    .FRAMES    (FRAMES)
  ) u_anim (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .title     (in_title),
    .frame_nxt (frame_nxt)
  );

  always_comb begin
    nib_d = nib_q;
    if (in_stage && (entry || tick)) begin
      case (slot)
        2'd0:    nib_d[3:0]  = frame_nxt;
        2'd1:    nib_d[7:4]  = frame_nxt;
        default: nib_d[11:8] = frame_nxt;
      endcase
    end else if (in_title && (title_entry || tick)) begin
      nib_d = {3{frame_nxt}};
    end
  end

  // Clamping never feeds back here: walking into a wall stays in WALK.
  always_comb begin
    fsm_d = fsm_q;
    if (!in_stage)  fsm_d = FROZEN;
    else if (entry) fsm_d = IDLE;
    else if (tick)  fsm_d = move ? WALK : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= TITLE;
      fsm_q  <= FROZEN;
      x_q    <= START_XV;
      y_q    <= START_YV;
      nib_q  <= '0;
    end else begin
      prev_q <= state;
      fsm_q  <= fsm_d;
      nib_q  <= nib_d;
      if (entry) begin
        x_q <= START_XV;
        y_q <= START_YV;
      end else if (stage_tick) begin
        x_q <= nx;
        y_q <= ny;
      end
    end
  end

  assign player_x     = {18'd0, x_q};
  assign player_y     = {18'd0, y_q};
  assign player_state = nib_q;
  assign moving       = (fsm_q == WALK);

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: vector table, directed corner sequences, randomized run vs reference model.
module tb_player_motion;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  state;
  logic        tick;
  logic        key_up, key_down, key_left, key_right;
  logic [26:0] player_x, player_y;
  logic [11:0] player_state;
  logic        moving;

  always #5 clk = ~clk;

  player_motion dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .state        (state),
    .tick         (tick),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_left     (key_left),
    .key_right    (key_right),
    .player_x     (player_x),
    .player_y     (player_y),
    .player_state (player_state),
    .moving       (moving)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Reference model: plain integer bookkeeping of position, walk flag, tick count and frames.
  int m_x, m_y, m_div, m_prev;
  int m_nib[3];
  bit m_walk;

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic int m_ps();
    return (m_nib[2] << 8) | (m_nib[1] << 4) | m_nib[0];
  endfunction

  task automatic model_reset();
    m_x = 10; m_y = 110; m_div = 0; m_prev = 0; m_walk = 0;
    for (int j = 0; j < 3; j++) m_nib[j] = 0;
  endtask

  task automatic model_step(input int st, input bit tk, input bit u, input bit d, input bit l, input bit r);
    int dx, dy, k;
    if (st == 2 || st == 4 || st == 6) begin
      k = st / 2 - 1;
      if (st != m_prev) begin
        m_x = 10; m_y = 110; m_nib[k] = 0; m_div = 0; m_walk = 0;
      end else if (tk) begin
        dx = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        dy = (d && !u) ? 1 : ((u && !d) ? -1 : 0);
        m_x = clampi(m_x + dx, 310);
        m_y = clampi(m_y + dy, 230);
        if (dx != 0 || dy != 0) begin
          m_walk = 1;
          m_div++;
          if (m_div == 8) begin
            m_div = 0;
            m_nib[k] = (m_nib[k] + 1) % 4;
          end
        end else begin
          m_walk = 0; m_div = 0; m_nib[k] = 0;
        end
      end
    end else begin
      m_walk = 0;
      if (st == 0) begin
        if (m_prev != 0) begin
          m_div = 0;
          for (int j = 0; j < 3; j++) m_nib[j] = 0;
        end else if (tk) begin
          m_div++;
          if (m_div == 16) begin
            m_div = 0;
            for (int j = 0; j < 3; j++) m_nib[j] = (m_nib[j] + 1) % 4;
          end
        end
      end
    end
    m_prev = st;
  endtask

  task automatic drive(input logic [3:0] st, input logic tk, input logic u, input logic d,
                       input logic l, input logic r);
    state = st; tick = tk; key_up = u; key_down = d; key_left = l; key_right = r;
    @(posedge clk);
    #1;
    model_step(int'(st), tk, u, d, l, r);
  endtask

  typedef struct {
    logic [3:0] st;
    logic       tk;
    logic [3:0] keys;   // {up, down, left, right}
    int         ex;
    int         ey;
    int         eps;
    int         emv;
  } vec_t;

  vec_t vecs[12];
  logic [3:0] codes[7];

  initial begin
    int cur;
    bit bias, u, d, l, r;

    vecs[0]  = '{4'd2, 1'b0, 4'b0000, 10, 110, 0, 0};
    vecs[1]  = '{4'd2, 1'b1, 4'b0001, 11, 110, 0, 1};
    vecs[2]  = '{4'd2, 1'b1, 4'b0001, 12, 110, 0, 1};
    vecs[3]  = '{4'd2, 1'b1, 4'b0001, 13, 110, 0, 1};
    vecs[4]  = '{4'd2, 1'b1, 4'b0000, 13, 110, 0, 0};
    vecs[5]  = '{4'd4, 1'b1, 4'b0001, 10, 110, 0, 0};
    vecs[6]  = '{4'd4, 1'b1, 4'b0111, 10, 111, 0, 1};
    vecs[7]  = '{4'd4, 1'b1, 4'b1000, 10, 110, 0, 1};
    vecs[8]  = '{4'd4, 1'b0, 4'b0001, 10, 110, 0, 1};
    vecs[9]  = '{4'd3, 1'b1, 4'b0001, 10, 110, 0, 0};
    vecs[10] = '{4'd4, 1'b1, 4'b0000, 10, 110, 0, 0};
    vecs[11] = '{4'd4, 1'b1, 4'b0010,  9, 110, 0, 1};
    codes = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd1, 4'd3, 4'd9};

    rst_n = 1'b0; state = 4'd0; tick = 1'b0;
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset x", int'(player_x), 10);
    chk("reset y", int'(player_y), 110);
    chk("reset player_state", int'(player_state), 0);
    chk("reset moving", int'(moving), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].st, vecs[i].tk, vecs[i].keys[3], vecs[i].keys[2], vecs[i].keys[1], vecs[i].keys[0]);
      chk($sformatf("vec%0d x", i), int'(player_x), vecs[i].ex);
      chk($sformatf("vec%0d y", i), int'(player_y), vecs[i].ey);
      chk($sformatf("vec%0d player_state", i), int'(player_state), vecs[i].eps);
      chk($sformatf("vec%0d moving", i), int'(moving), vecs[i].emv);
    end

    // Walk animation: frame 1 at tick 8, frame 2 at tick 16, reset to 0 on release.
    drive(4'd2, 1'b0, 0, 0, 0, 0);
    for (int t = 1; t <= 16; t++) begin
      drive(4'd2, 1'b1, 0, 0, 0, 1);
      if (t == 7)  chk("anim t7",  int'(player_state[3:0]), 0);
      if (t == 8)  chk("anim t8",  int'(player_state[3:0]), 1);
      if (t == 15) chk("anim t15", int'(player_state[3:0]), 1);
      if (t == 16) chk("anim t16", int'(player_state[3:0]), 2);
    end
    chk("anim x", int'(player_x), 26);
    drive(4'd2, 1'b1, 0, 0, 0, 0);
    chk("release frame", int'(player_state[3:0]), 0);
    chk("release moving", int'(moving), 0);

    // Right wall.
    for (int t = 0; t < 283; t++) drive(4'd2, 1'b1, 0, 0, 0, 1);
    chk("wall x pre", int'(player_x), 309);
    for (int t = 0; t < 5; t++) begin
      drive(4'd2, 1'b1, 0, 0, 0, 1);
      chk("wall x sat", int'(player_x), 310);
    end
    chk("wall moving", int'(moving), 1);

    // Left wall: walking into x=0 keeps animating.
    drive(4'd3, 1'b0, 0, 0, 0, 0);
    drive(4'd2, 1'b0, 0, 0, 0, 0);
    for (int t = 0; t < 10; t++) drive(4'd2, 1'b1, 0, 0, 1, 0);
    chk("lwall x0", int'(player_x), 0);
    chk("lwall frame1", int'(player_state[3:0]), 1);
    for (int t = 0; t < 8; t++) drive(4'd2, 1'b1, 0, 0, 1, 0);
    chk("lwall x hold", int'(player_x), 0);
    chk("lwall frame2", int'(player_state[3:0]), 2);
    chk("lwall moving", int'(moving), 1);

    // Stage change coincident with a tick: the tick is discarded.
    drive(4'd4, 1'b1, 0, 0, 0, 1);
    chk("swap x", int'(player_x), 10);
    chk("swap y", int'(player_y), 110);
    chk("swap player_state", int'(player_state), 12'h002);
    chk("swap moving", int'(moving), 0);

    // Title screen animation.
    drive(4'd0, 1'b0, 0, 0, 0, 0);
    chk("title entry ps", int'(player_state), 0);
    for (int t = 1; t <= 32; t++) begin
      drive(4'd0, 1'b1, 0, 0, 0, 1);
      if (t == 31) chk("title t31", int'(player_state), 12'h111);
    end
    chk("title t32", int'(player_state), 12'h222);
    chk("title x", int'(player_x), 10);
    chk("title y", int'(player_y), 110);
    chk("title moving", int'(moving), 0);

    // Async reset mid-walk at x=200.
    drive(4'd2, 1'b0, 0, 0, 0, 0);
    chk("stage2 entry ps", int'(player_state), 12'h220);
    for (int t = 0; t < 190; t++) drive(4'd2, 1'b1, 0, 0, 0, 1);
    chk("prereset x", int'(player_x), 200);
    chk("prereset moving", int'(moving), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst x", int'(player_x), 10);
    chk("arst y", int'(player_y), 110);
    chk("arst player_state", int'(player_state), 0);
    chk("arst moving", int'(moving), 0);
    model_reset();
    #1 rst_n = 1'b1;
    drive(4'd2, 1'b1, 0, 0, 0, 1);
    chk("post-reset reload x", int'(player_x), 10);
    chk("post-reset moving", int'(moving), 0);
    drive(4'd2, 1'b1, 0, 0, 0, 1);
    chk("post-reset step x", int'(player_x), 11);
    chk("post-reset step moving", int'(moving), 1);

    // Randomized run against the reference model.
    cur = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) cur = int'(codes[$urandom_range(6)]);
      bias = (i < 1500);
      r = bias ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      l = bias ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      d = bias ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      u = bias ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      drive(4'(cur), 1'($urandom_range(1)), u, d, l, r);
      chk("rand x", int'(player_x), m_x);
      chk("rand y", int'(player_y), m_y);
      chk("rand player_state", int'(player_state), m_ps());
      chk("rand moving", int'(moving), int'(m_walk));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
